// File: rtl/typed_handle_allocator.sv
// typed_handle_allocator
//   Hands out object handles from NUM_TYPES independent pools of HANDLES
//   entries each. A request names a type. The response carries the lowest
//   free index of that pool, or an error when the pool is exhausted or the
//   type is out of range. Handles come back through a release strobe.
//
// Ports
//   clk, rst_n        clock (rising edge), asynchronous active-low reset
//   req_valid/ready   allocate request handshake, req_type selects the pool
//   rsp_valid/ready   result handshake. rsp_type echoes the type, rsp_idx
//                     holds the index (0 on error), rsp_err flags failure.
//   rel_valid         release strobe for handle (rel_type, rel_idx). It has
//                     no backpressure.
//   flush             synchronous return of every handle. It also drops any
//                     pending response.
//   free_cnt          per-pool free count. Pool t is at [t*(IDX_W+1) +: IDX_W+1].
//   dbl_free          sticky flag for ignored releases
//
// Build option
//   TYPED_ALLOC_DBL_FREE_CHECK_EN : when defined, an ignored release sets
//   dbl_free. The flag is cleared only by reset or flush. When the macro is
//   undefined, dbl_free is tied to 0.

module typed_handle_allocator #(
  parameter int NUM_TYPES = 3,
  parameter int HANDLES   = 8,
  parameter int TYPE_W    = (NUM_TYPES > 1) ? $clog2(NUM_TYPES) : 1,
  parameter int IDX_W     = (HANDLES > 1) ? $clog2(HANDLES) : 1
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             req_valid,
  output logic                             req_ready,
  input  logic [TYPE_W-1:0]                req_type,
  output logic                             rsp_valid,
  input  logic                             rsp_ready,
  output logic [TYPE_W-1:0]                rsp_type,
  output logic [IDX_W-1:0]                 rsp_idx,
  output logic                             rsp_err,
  input  logic                             rel_valid,
  input  logic [TYPE_W-1:0]                rel_type,
  input  logic [IDX_W-1:0]                 rel_idx,
  input  logic                             flush,
  output logic [NUM_TYPES*(IDX_W+1)-1:0]   free_cnt,
  output logic                             dbl_free
);

  localparam int CNT_W = IDX_W + 1;

  typedef enum logic {EMPTY = 1'b0, HOLD = 1'b1} state_t;

  state_t                                 r_state;
  logic [NUM_TYPES-1:0][HANDLES-1:0]      r_bitmap;   // 1 = free
  logic [NUM_TYPES-1:0][CNT_W-1:0]        r_cnt;

  logic [NUM_TYPES-1:0][HANDLES-1:0]      w_bitmap_next;
  logic [NUM_TYPES-1:0][CNT_W-1:0]        w_cnt_next;
  logic                                   w_accept;
  logic                                   w_req_type_ok;
  logic [HANDLES-1:0]                     w_req_map;
  logic [IDX_W-1:0]                       w_low_idx;
  logic                                   w_alloc_ok;
  logic                                   w_rel_ok;
  logic [HANDLES-1:0]                     w_alloc_mask;
  logic [HANDLES-1:0]                     w_rel_mask;

  // Single-entry skid: a held result may be replaced in the same cycle it
  // is consumed.
  assign req_ready = (r_state == EMPTY) || rsp_ready;
  assign rsp_valid = (r_state == HOLD);
  assign w_accept  = req_valid && req_ready;

  assign w_req_type_ok = int'(req_type) < NUM_TYPES;

  always_comb begin
    w_req_map = '0;
    if (w_req_type_ok)
      w_req_map = r_bitmap[req_type];
  end

  // Lowest free index of the requested pool. The scan runs high to low, so
  // the last hit is the lowest bit.
  always_comb begin
    w_low_idx = '0;
    for (int i = HANDLES - 1; i >= 0; i--)
      if (w_req_map[i])
        w_low_idx = IDX_W'(i);
  end

  // A flush swallows the accept, so no handle is consumed.
  assign w_alloc_ok   = w_accept && !flush && (w_req_map != '0);
  assign w_alloc_mask = HANDLES'(1) << w_low_idx;
  assign w_rel_mask   = HANDLES'(1) << rel_idx;

  // A release is legal only for an in-range handle that is currently
  // allocated. The check uses the pre-allocation bitmap, so a handle freed
  // in the same cycle cannot be picked by the concurrent allocation.
  always_comb begin
    w_rel_ok = 1'b0;
    if (rel_valid && (int'(rel_type) < NUM_TYPES) && (int'(rel_idx) < HANDLES))
      w_rel_ok = ~r_bitmap[rel_type][rel_idx];
  end

  genvar gi;
  generate
    for (gi = 0; gi < NUM_TYPES; gi++) begin : g_pool
      logic w_alloc_hit;
      logic w_rel_hit;

      assign w_alloc_hit = w_alloc_ok && (req_type == TYPE_W'(gi));
      assign w_rel_hit   = w_rel_ok && !flush && (rel_type == TYPE_W'(gi));

      assign w_bitmap_next[gi] = flush ? {HANDLES{1'b1}} :
          ((r_bitmap[gi] & ~(w_alloc_hit ? w_alloc_mask : '0)) |
           (w_rel_hit ? w_rel_mask : '0));

      // An allocation and a release in the same pool cancel out in the count.
      assign w_cnt_next[gi] = flush ? CNT_W'(HANDLES) :
          (r_cnt[gi] - CNT_W'(w_alloc_hit) + CNT_W'(w_rel_hit));

      assign free_cnt[gi*CNT_W +: CNT_W] = r_cnt[gi];
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_bitmap <= '1;
      for (int t = 0; t < NUM_TYPES; t++)
        r_cnt[t] <= CNT_W'(HANDLES);
    end else begin
      r_bitmap <= w_bitmap_next;
      r_cnt    <= w_cnt_next;
    end
  end

  // Response FSM and its registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= EMPTY;
      rsp_type <= '0;
      rsp_idx  <= '0;
      rsp_err  <= 1'b0;
    end else if (flush) begin
      r_state <= EMPTY;
    end else if (w_accept) begin
      r_state  <= HOLD;
      rsp_type <= req_type;
      rsp_idx  <= w_alloc_ok ? w_low_idx : '0;
      rsp_err  <= !w_alloc_ok;
    end else if (rsp_ready) begin
      r_state <= EMPTY;
    end
  end

`ifdef TYPED_ALLOC_DBL_FREE_CHECK_EN
  logic r_dbl_free;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      r_dbl_free <= 1'b0;
    else if (flush)
      r_dbl_free <= 1'b0;
    else if (rel_valid && !w_rel_ok)
      r_dbl_free <= 1'b1;
  end

  assign dbl_free = r_dbl_free;
`else
  assign dbl_free = 1'b0;
`endif

endmodule

// File: tb/tb_typed_handle_allocator.sv
// Testbench for typed_handle_allocator (NUM_TYPES=3, HANDLES=8).
// The bench keeps a reference model of each pool as a set of free bits.
// Every accepted request pushes its expected response into a scoreboard
// queue. A monitor pops and compares each response when it is consumed.

module tb_typed_handle_allocator;

  localparam int NT = 3;
  localparam int NH = 8;
`ifdef TYPED_ALLOC_DBL_FREE_CHECK_EN
  localparam bit DBL_EN = 1'b1;
`else
  localparam bit DBL_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [1:0]  req_type = '0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [1:0]  rsp_type;
  logic [2:0]  rsp_idx;
  logic        rsp_err;
  logic        rel_valid = 1'b0;
  logic [1:0]  rel_type = '0;
  logic [2:0]  rel_idx = '0;
  logic        flush = 1'b0;
  logic [11:0] free_cnt;
  logic        dbl_free;

  typed_handle_allocator #(.NUM_TYPES(NT), .HANDLES(NH)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_type(req_type),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_type(rsp_type),
    .rsp_idx(rsp_idx), .rsp_err(rsp_err),
    .rel_valid(rel_valid), .rel_type(rel_type), .rel_idx(rel_idx),
    .flush(flush), .free_cnt(free_cnt), .dbl_free(dbl_free)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0] typ;
    logic [2:0] idx;
    logic       err;
  } exp_t;

  exp_t     sb[$];
  exp_t     mon_e;
  bit [7:0] m_map[NT];   // reference pools: bit set = handle free
  bit       m_hold;      // a response is currently being presented
  bit       m_dbl;
  int       n_vec = 0;
  int       n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int t = 0; t < NT; t++) m_map[t] = 8'hFF;
    m_hold = 1'b0;
    m_dbl  = 1'b0;
    sb.delete();
  endtask

  // One clock cycle: drive the inputs, check the state visible now, then
  // advance the model by what the coming edge must do.
  task automatic step(input bit rv, input bit [1:0] rt, input bit rr,
                      input bit lv, input bit [1:0] lt, input bit [2:0] li,
                      input bit fl);
    bit [7:0] pre[NT];
    bit       acc;
    int       lo;
    exp_t     e;
    @(posedge clk); #1;
    req_valid = rv; req_type = rt; rsp_ready = rr;
    rel_valid = lv; rel_type = lt; rel_idx = li; flush = fl;
    #1;
    chk("req_ready", 32'(req_ready), 32'(!m_hold || rr));
    chk("rsp_valid", 32'(rsp_valid), 32'(m_hold));
    chk("dbl_free",  32'(dbl_free),  32'(m_dbl));
    for (int t = 0; t < NT; t++)
      chk($sformatf("free_cnt[%0d]", t), 32'(free_cnt[t*4 +: 4]), 32'($countones(m_map[t])));
    $display("cyc rv=%0d rt=%0d rr=%0d rel=%0d:%0d/%0d fl=%0d", rv, rt, rr, lv, lt, li, fl);

    for (int t = 0; t < NT; t++) pre[t] = m_map[t];
    acc = rv && (!m_hold || rr);
    if (fl) begin
      // An unconsumed held response is discarded by the flush.
      if (m_hold && !rr && sb.size() > 0) void'(sb.pop_back());
      for (int t = 0; t < NT; t++) m_map[t] = 8'hFF;
      m_hold = 1'b0;
      m_dbl  = 1'b0;
    end else begin
      if (acc) begin
        e.typ = rt; e.idx = 3'd0; e.err = 1'b1;
        if (rt < NT && pre[rt] != 8'h00) begin
          lo = 0;
          while (!pre[rt][lo]) lo++;
          m_map[rt][lo] = 1'b0;
          e.idx = 3'(lo);
          e.err = 1'b0;
        end
        sb.push_back(e);
        m_hold = 1'b1;
      end else if (rr) begin
        m_hold = 1'b0;
      end
      if (lv) begin
        if (lt < NT && !pre[lt][li]) m_map[lt][li] = 1'b1;
        else if (DBL_EN) m_dbl = 1'b1;
      end
    end
  endtask

  task automatic idle(input bit rr);
    step(0, 0, rr, 0, 0, 0, 0);
  endtask

  // Monitor: each consumed response must match the head of the scoreboard.
  always @(negedge clk) begin
    if (rst_n && rsp_valid && rsp_ready) begin
      if (sb.size() == 0) begin
        chk("rsp_unexpected", 32'd1, 32'd0);
      end else begin
        mon_e = sb.pop_front();
        chk("rsp_type", 32'(rsp_type), 32'(mon_e.typ));
        chk("rsp_idx",  32'(rsp_idx),  32'(mon_e.idx));
        chk("rsp_err",  32'(rsp_err),  32'(mon_e.err));
        $display("rsp type=%0d idx=%0d err=%0d", rsp_type, rsp_idx, rsp_err);
      end
    end
  end

  initial begin
    model_reset();
    repeat (2) @(posedge clk);
    #2;
    chk("reset rsp_valid", 32'(rsp_valid), 32'd0);
    chk("reset req_ready", 32'(req_ready), 32'd1);
    chk("reset rsp_type",  32'(rsp_type),  32'd0);
    chk("reset rsp_idx",   32'(rsp_idx),   32'd0);
    chk("reset rsp_err",   32'(rsp_err),   32'd0);
    chk("reset dbl_free",  32'(dbl_free),  32'd0);
    chk("reset free_cnt",  32'(free_cnt),  32'h888);
    rst_n = 1'b1;

    // Drain pool 1 completely. The ninth request must return an error.
    for (int i = 0; i < 9; i++) step(1, 1, 1, 0, 0, 0, 0);
    idle(1);

    // Return two handles. They must come back lowest first.
    step(0, 0, 1, 1, 1, 5, 0);
    step(0, 0, 1, 1, 1, 2, 0);
    step(1, 1, 1, 0, 0, 0, 0);
    step(1, 1, 1, 0, 0, 0, 0);
    idle(1);

    // Backpressure: the held result must persist while the request stalls.
    step(1, 0, 1, 0, 0, 0, 0);
    for (int i = 0; i < 4; i++) step(1, 0, 0, 0, 0, 0, 0);
    step(1, 0, 1, 0, 0, 0, 0);
    idle(1);

    // Empty pool 0, then request while releasing idx 3 in the same cycle.
    for (int i = 0; i < 6; i++) step(1, 0, 1, 0, 0, 0, 0);
    step(1, 0, 1, 1, 0, 3, 0);
    step(1, 0, 1, 0, 0, 0, 0);
    idle(1);

    // Illegal releases: an already-free handle, and an out-of-range type.
    step(0, 0, 1, 1, 2, 4, 0);
    idle(1);
    step(0, 0, 1, 1, 3, 0, 0);
    idle(1);
    step(0, 0, 1, 0, 0, 0, 1);
    idle(1);

    // Flush while a response is held and not consumed.
    step(1, 2, 1, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 1);
    idle(1);

    // Asynchronous reset while HOLD is active.
    step(1, 2, 0, 0, 0, 0, 0);
    @(posedge clk); #2;
    chk("hold before reset", 32'(rsp_valid), 32'd1);
    rst_n = 1'b0;
    req_valid = 1'b0; rel_valid = 1'b0; flush = 1'b0;
    #1;
    chk("async reset rsp_valid", 32'(rsp_valid), 32'd0);
    model_reset();
    #3 rst_n = 1'b1;
    idle(1);

    // Randomised traffic.
    for (int i = 0; i < 600; i++)
      step($urandom_range(0, 3) != 0, 2'($urandom_range(0, 3)),
           $urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)),
           2'($urandom_range(0, 3)), 3'($urandom_range(0, 7)),
           $urandom_range(0, 63) == 0);

    repeat (3) idle(1);
    chk("scoreboard drained", 32'(sb.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
